// File: rtl/tick_capture_bank_if.sv
// tick_capture_bank_if
//   Bundles the switch-side inputs and LED-side outputs of tick_capture_bank.
//   master: drives switches/controls and observes the display (board or bench).
//   slave : the capture bank itself.
//   Signals
//     D          switch data, WIDTH bits
//     en         capture enable, active-high
//     mode       00 PASS, 01 LATCH, 10 EDGE, 11 PLAY
//     led        registered display value, WIDTH bits
//     phase_led  divider MSB (slow blink)
//     hist_count number of valid history entries
//     hist_full  hist_count == DEPTH
interface tick_capture_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] D;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] led;
  logic             phase_led;
  logic [CNT_W-1:0] hist_count;
  logic             hist_full;

  modport master (
    output D, en, mode,
    input  led, phase_led, hist_count, hist_full
  );

  modport slave (
    input  D, en, mode,
    output led, phase_led, hist_count, hist_full
  );
endinterface

// File: rtl/tick_capture_bank.sv
// tick_capture_bank
//   Switch-to-LED capture stage for board labs. A free-running divider gives a
//   slow phase and a one-cycle tick. Switch data is passed straight through,
//   latched during the high phase, or captured on ticks into a DEPTH-entry
//   history that can be replayed on the LEDs one entry per tick.
//   Ports
//     clk  system clock, all state on posedge
//     rst  asynchronous active-high reset (synchronous release expected)
//     bus  tick_capture_bank_if.slave: D, en, mode in; led, phase_led,
//          hist_count, hist_full out
module tick_capture_bank #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int DIV_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  tick_capture_bank_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_LATCH = 2'b01,
    MODE_EDGE  = 2'b10,
    MODE_PLAY  = 2'b11
  } mode_t;

  mode_t            mode_cur;
  mode_t            mode_prev;
  logic [DIV_BITS-1:0] cntr;
  logic             tick;
  logic             phase;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] hist [DEPTH];
  logic [CNT_W-1:0] hist_count;
  logic             hist_full;
  logic             push;
  logic             play_entry;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [WIDTH-1:0] led_r;
  logic [WIDTH-1:0] led_next;

  // Playback pointer advance: wraps after the newest valid entry, and parks
  // at 0 while the history is empty.
  function automatic logic [PTR_W-1:0] wrap_ptr(
    input logic [PTR_W-1:0] ptr,
    input logic [CNT_W-1:0] count
  );
    if (count == '0)
      return '0;
    if (CNT_W'(ptr) == count - CNT_W'(1))
      return '0;
    return ptr + PTR_W'(1);
  endfunction

  assign mode_cur   = mode_t'(bus.mode);
  assign tick       = (cntr == '1);
  assign phase      = cntr[DIV_BITS-1];
  assign hist_full  = (hist_count == CNT_W'(DEPTH));
  assign push       = (mode_cur == MODE_EDGE) && tick && bus.en;
  assign play_entry = (mode_cur == MODE_PLAY) && (mode_prev != MODE_PLAY);

  // Hold register: transparent in the high phase for LATCH, tick-sampled
  // for EDGE, untouched in PASS/PLAY.
  always_comb begin
    q_next = q;
    case (mode_cur)
      MODE_LATCH: if (bus.en && phase) q_next = bus.D;
      MODE_EDGE:  if (bus.en && tick)  q_next = bus.D;
      default:    q_next = q;
    endcase
  end

  // PLAY entry rewinds to the oldest entry and wins over a same-cycle tick.
  always_comb begin
    rd_ptr_next = rd_ptr;
    if (play_entry)
      rd_ptr_next = '0;
    else if ((mode_cur == MODE_PLAY) && tick)
      rd_ptr_next = wrap_ptr(rd_ptr, hist_count);
  end

  // The display register loads the post-edge view of the selected source,
  // so led equals q (or the playback entry) right after every edge.
  always_comb begin
    led_next = '0;
    case (mode_cur)
      MODE_PASS:  led_next = bus.D;
      MODE_LATCH: led_next = q_next;
      MODE_EDGE:  led_next = q_next;
      MODE_PLAY:  led_next = (hist_count == '0) ? '0 : hist[rd_ptr_next];
      default:    led_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntr       <= '0;
      q          <= '0;
      led_r      <= '0;
      hist_count <= '0;
      rd_ptr     <= '0;
      mode_prev  <= MODE_PASS;
      for (int i = 0; i < DEPTH; i++)
        hist[i] <= '0;
    end else begin
      cntr      <= cntr + DIV_BITS'(1);
      q         <= q_next;
      led_r     <= led_next;
      rd_ptr    <= rd_ptr_next;
      mode_prev <= mode_cur;
      if (push) begin
        // hist[0] is always the oldest entry; once full, the oldest drops
        // off and the rest slide down to make room at the top.
        if (hist_full) begin
          for (int i = 0; i < DEPTH - 1; i++)
            hist[i] <= hist[i+1];
          hist[DEPTH-1] <= bus.D;
        end else begin
          for (int i = 0; i < DEPTH; i++)
            if (CNT_W'(i) == hist_count)
              hist[i] <= bus.D;
          hist_count <= hist_count + CNT_W'(1);
        end
      end
    end
  end

  assign bus.led        = led_r;
  assign bus.phase_led  = phase;
  assign bus.hist_count = hist_count;
  assign bus.hist_full  = hist_full;

endmodule

// File: tb/tb_tick_capture_bank.sv
// tb_tick_capture_bank
//   Bench for tick_capture_bank with WIDTH=8, DEPTH=4, DIV_BITS=3.
//   A behavioural model pushes the expected outputs for every clock edge into a
//   scoreboard queue; a monitor pops and compares on the falling edge. Directed
//   checks against fixed values cover the reset, PASS, LATCH, EDGE and PLAY
//   scenarios.
module tb_tick_capture_bank;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int DIV_BITS = 3;

  typedef struct {
    logic [7:0] led;
    int         cnt;
    logic       full;
    logic       ph;
  } exp_t;

  logic clk;
  logic rst;

  tick_capture_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  tick_capture_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_BITS(DIV_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: history as a queue, oldest at the front.
  int         m_cnt = 0;
  logic [7:0] m_q = 8'h00;
  logic [7:0] m_led = 8'h00;
  logic [7:0] hq[$];
  int         m_rd = 0;
  logic [1:0] m_mprev = 2'b00;
  logic       m_last_tick = 1'b0;
  exp_t       sb[$];

  task automatic model_reset();
    m_cnt = 0; m_q = 8'h00; m_led = 8'h00; hq.delete();
    m_rd = 0; m_mprev = 2'b00; m_last_tick = 1'b0;
  endtask

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      model_reset();
    end else begin
      logic tk, ph;
      tk = (m_cnt == 7);
      ph = (m_cnt >= 4);
      case (bus.mode)
        2'b00: m_led = bus.D;
        2'b01: begin
          if (bus.en && ph) m_q = bus.D;
          m_led = m_q;
        end
        2'b10: begin
          if (tk && bus.en) begin
            m_q = bus.D;
            if (hq.size() == DEPTH) void'(hq.pop_front());
            hq.push_back(bus.D);
          end
          m_led = m_q;
        end
        default: begin
          if (m_mprev != 2'b11) m_rd = 0;
          else if (tk) m_rd = (hq.size() == 0 || m_rd == hq.size() - 1) ? 0 : m_rd + 1;
          m_led = (hq.size() == 0) ? 8'h00 : hq[m_rd];
        end
      endcase
      m_mprev     = bus.mode;
      m_last_tick = tk;
      m_cnt       = (m_cnt + 1) % 8;
    end
    e.led  = m_led;
    e.cnt  = hq.size();
    e.full = (hq.size() == DEPTH);
    e.ph   = (m_cnt >= 4);
    sb.push_back(e);
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_led",   bus.led,        e.led);
      check("sb_count", bus.hist_count, e.cnt);
      check("sb_full",  bus.hist_full,  e.full);
      check("sb_phase", bus.phase_led,  e.ph);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until the edge just taken was a tick edge; bounded.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_last_tick && n < 16);
    check(tag, (n < 16), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] play_exp [4];
    play_exp[0] = 8'h33; play_exp[1] = 8'h44; play_exp[2] = 8'h55; play_exp[3] = 8'h22;

    // T1: reset with random inputs
    rst = 1'b1; bus.D = 8'h00; bus.en = 1'b0; bus.mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.D = 8'($urandom); bus.en = 1'($urandom); bus.mode = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    check("t1_led",   bus.led,        0);
    check("t1_count", bus.hist_count, 0);
    check("t1_full",  bus.hist_full,  0);
    check("t1_phase", bus.phase_led,  0);
    rst = 1'b0; bus.D = 8'h00; bus.en = 1'b0; bus.mode = 2'b00;
    edges(3);
    check("t1_phase_e3", bus.phase_led, 0);
    edges(1);
    check("t1_phase_e4", bus.phase_led, 1);
    edges(3);
    check("t1_phase_e7", bus.phase_led, 1);
    edges(1);
    check("t1_phase_e8", bus.phase_led, 0);

    // T2: PASS
    bus.D = 8'hA5;
    edges(1);
    check("t2_led_a5", bus.led, 8'hA5);
    bus.D = 8'h3C;
    edges(1);
    check("t2_led_3c", bus.led, 8'h3C);

    // T3: LATCH, starting with the divider at 0
    wait_tick("t3_align");
    bus.mode = 2'b01; bus.en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.D = 8'h40 + 8'(k);
      edges(1);
      if (k == 3) check("t3_low_phase", bus.led, 8'h00);
      if (k == 5) check("t3_track", bus.led, 8'h45);
    end
    check("t3_latched", bus.led, 8'h47);
    for (int k = 0; k < 4; k++) begin
      bus.D = 8'h80 + 8'(k);
      edges(1);
      check("t3_hold_low", bus.led, 8'h47);
    end
    bus.en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.D = 8'($urandom);
      edges(1);
      check("t3_hold_en0", bus.led, 8'h47);
    end

    // T4: EDGE pushes
    bus.mode = 2'b10; bus.en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.D = 8'h11 * 8'(k + 1);
      wait_tick("t4_wait");
      check("t4_led", bus.led, 8'h11 * 8'(k + 1));
      if (k == 0) check("t4_count1", bus.hist_count, 1);
    end
    check("t4_count", bus.hist_count, 4);
    check("t4_full",  bus.hist_full,  1);
    bus.en = 1'b0; bus.D = 8'h99;
    wait_tick("t4_wait_en0");
    check("t4_en0_count", bus.hist_count, 4);
    check("t4_en0_led",   bus.led,        8'h55);

    // T5: PLAY
    bus.mode = 2'b11;
    edges(1);
    check("t5_entry", bus.led, 8'h22);
    for (int k = 0; k < 4; k++) begin
      wait_tick("t5_wait");
      check("t5_play", bus.led, play_exp[k]);
    end
    bus.mode = 2'b10;
    edges(1);
    bus.mode = 2'b11;
    edges(1);
    check("t5_reentry", bus.led, 8'h22);
    check("t5_count",   bus.hist_count, 4);

    // T6: asynchronous reset mid-PLAY
    edges(1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_led",   bus.led,        0);
    check("t6_async_count", bus.hist_count, 0);
    check("t6_async_full",  bus.hist_full,  0);
    check("t6_async_phase", bus.phase_led,  0);
    edges(2);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_tick("t6_wait");
      check("t6_empty_led",   bus.led,        0);
      check("t6_empty_count", bus.hist_count, 0);
    end

    edges(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
